// File: rtl/mips_dmem_responder_pkg.sv
// Shared state encoding, widths and address-check helper for the data-memory responder.
package mips_dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Misaligned, or any byte-address bit above the word array is set.
    function automatic logic addr_error(input logic [31:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Word-organised data store: synchronous byte-enable write, combinational read, no reset.
module mips_dmem_array
    import mips_dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: accepts one access at a time, inserts WAIT_CYCLES wait
// states, then pulses ready for one cycle with read data or an address error.
module mips_dmem_responder
    import mips_dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        be,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic              r_ready;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic              w_enter_done;
    logic              w_sel_we;
    logic              w_sel_err;
    logic              w_mem_we;
    logic [31:0]       w_sel_addr;
    logic [DATA_W-1:0] w_mem_rdata;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // With zero wait states DONE is entered on the accept edge itself, so the
    // completion data must come from the live inputs rather than the latches.
    assign w_sel_addr   = (r_state == ST_IDLE) ? addr : r_addr;
    assign w_sel_we     = (r_state == ST_IDLE) ? we   : r_we;
    assign w_sel_err    = addr_error(w_sel_addr, ADDR_WIDTH);
    assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
    assign w_mem_we     = (r_state == ST_DONE) && r_we && !addr_error(r_addr, ADDR_WIDTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_ready <= w_enter_done;
            r_err   <= w_enter_done && w_sel_err;
            r_rdata <= (w_enter_done && !w_sel_err && !w_sel_we) ? w_mem_rdata : '0;
        end
    end

    mips_dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_waddr (r_addr[ADDR_WIDTH+1:2]),
        .i_wdata (r_wdata),
        .i_raddr (w_sel_addr[ADDR_WIDTH+1:2]),
        .o_rdata (w_mem_rdata)
    );

    assign ready = r_ready;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: two instances (0 and 2 wait states) checked every
// cycle against a transaction-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mips_dmem_responder;
    import mips_dmem_responder_pkg::*;

    logic              clk;
    logic              reset;
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              rdy0, err0, rdy2, err2;
    logic [DATA_W-1:0] rd0, rd2;

    int tests = 0;
    int fails = 0;

    mips_dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ready(rdy0), .rdata(rd0), .err(err0));

    mips_dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ready(rdy2), .rdata(rd2), .err(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model; index 0 -> zero wait states, index 1 -> two.
    int unsigned ncyc [2] = '{0, 0};
    int unsigned due [2] = '{0, 0};
    int unsigned idle_from [2] = '{0, 0};
    bit          pend [2] = '{0, 0};
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be [2];
    logic [31:0] mmem [2][256];
    logic        exp_ready [2] = '{0, 0};
    logic        exp_err [2] = '{0, 0};
    logic [31:0] exp_rdata [2] = '{0, 0};

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    task automatic model_step(input int k);
        int unsigned n;
        int unsigned w;
        int unsigned ix;
        w = (k == 1) ? 2 : 0;
        ncyc[k] = ncyc[k] + 1;
        n = ncyc[k];
        exp_ready[k] = 1'b0;
        exp_err[k]   = 1'b0;
        exp_rdata[k] = '0;
        // Write lands on the edge that ends the completion cycle.
        if (pend[k] && n == due[k] + 1) begin
            if (m_we[k] && !bad_addr(m_addr[k])) begin
                ix = m_addr[k] / 4;
                for (int b = 0; b < 4; b++)
                    if (m_be[k][b]) mmem[k][ix][8*b +: 8] = m_wdata[k][8*b +: 8];
            end
            pend[k] = 1'b0;
        end
        if (!pend[k] && n >= idle_from[k] && req) begin
            m_we[k] = we; m_addr[k] = addr; m_wdata[k] = wdata; m_be[k] = be;
            due[k] = n + w;
            idle_from[k] = n + w + 2;
            pend[k] = 1'b1;
        end
        if (pend[k] && n == due[k]) begin
            exp_ready[k] = 1'b1;
            if (bad_addr(m_addr[k])) exp_err[k] = 1'b1;
            else if (!m_we[k]) exp_rdata[k] = mmem[k][m_addr[k] / 4];
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                pend[k] = 1'b0;
                idle_from[k] = ncyc[k] + 1;
                exp_ready[k] = 1'b0;
                exp_err[k] = 1'b0;
                exp_rdata[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic cmp(input string name, input int k, input logic r, input logic e,
                       input logic [31:0] d);
        tests++;
        if ({r, e, d} !== {exp_ready[k], exp_err[k], exp_rdata[k]}) begin
            fails++;
            $display("FAIL %s t=%0t got ready=%b err=%b rdata=%h exp ready=%b err=%b rdata=%h",
                     name, $time, r, e, d, exp_ready[k], exp_err[k], exp_rdata[k]);
        end
    endtask

    always @(negedge clk) begin
        cmp("w0_outputs", 0, rdy0, err0, rd0);
        cmp("w2_outputs", 1, rdy2, err2, rd2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // One access timed on the 2-wait-state instance; inputs are scrambled while busy.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
        lat = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy2) begin
                lat = i; rd = rd2; er = err2;
                break;
            end
        end
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL ready_timeout got no ready within 20 cycles exp ready");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got simulation still running exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cnt;
        logic [31:0] a;

        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, rdy2}, 32'd0);
        chk("reset_rdata", rd2, 32'd0);
        #1 reset = 1'b1;

        for (int i = 0; i < 256; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF, rd, er, lat);

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_err", {31'd0, er}, 32'd0);
        chk("wr_rdata", rd, 32'd0);
        access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'd0, er}, 32'd0);

        access(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("partial_write", rd, 32'hDE22BE44);

        access(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        chk("misalign_err", {31'd0, er}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        access(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
        chk("range_err", {31'd0, er}, 32'd1);
        chk("range_rdata", rd, 32'd0);
        access(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        chk("misalign_wr_err", {31'd0, er}, 32'd1);
        access(1'b1, 32'h410, 32'h00000000, 4'hF, rd, er, lat);
        chk("range_wr_err", {31'd0, er}, 32'd1);
        access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        chk("be0_err", {31'd0, er}, 32'd0);
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("mem_unchanged", rd, 32'hDE22BE44);

        access(1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
        @(negedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy2) cnt++;
            if (i == 0) #1 reset = 1'b1;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        chk("abort_no_write", rd, 32'h12345678);

        @(negedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy0) cnt++;
        end
        #1 req = 1'b0;
        chk("w0_back_to_back", 32'(cnt), 32'd5);
        repeat (5) @(negedge clk);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0: a = 32'($urandom_range(0, 255) << 2) | 32'($urandom_range(1, 3));
                1: a = ($urandom & 32'hFFFF_FFFC) | 32'h400;
                default: a = 32'($urandom_range(0, 255) << 2);
            endcase
            access(1'($urandom), a, $urandom, 4'($urandom), rd, er, lat);
            chk("rnd_latency", 32'(lat), 32'd3);
            chk("rnd_err", {31'd0, er}, {31'd0, bad_addr(a)});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_dmem_responder.md
MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width (256 x 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, added wait states per access (range 0-15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port req  input  1  initiator access request; sampled only in IDLE.
REQ-006 Port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 Port addr  input  32  byte address; sampled with req.
REQ-008 Port wdata  input  32  write data; sampled with req.
REQ-009 Port be  input  4  byte enables, be[0] = bits 7:0; sampled with req.
REQ-010 Port ready  output  1  one-cycle pulse marking access completion.
REQ-011 Port rdata  output  32  read data; valid only while ready=1.
REQ-012 Port err  output  1  error flag; valid only while ready=1.

Function
REQ-013 FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY when req=1 and WAIT_CYCLES>0.
- IDLE->DONE when req=1 and WAIT_CYCLES=0.
- BUSY->DONE when the wait counter reaches 0.
- DONE->IDLE unconditionally.
REQ-014 On the req-accept edge, latch we, addr, wdata and be, and load the wait counter with WAIT_CYCLES-1.
REQ-015 In BUSY, decrement the counter by 1 per cycle; ignore all input changes.
REQ-016 Latency: ready=1 exactly WAIT_CYCLES+1 cycles after the accept edge, for exactly one cycle (state DONE).
REQ-017 Ignore req while in DONE; a new access is accepted no earlier than the cycle after DONE (minimum spacing WAIT_CYCLES+2 cycles).
REQ-018 Error condition: latched addr[1:0]!=0 (misaligned) or latched addr[31:ADDR_WIDTH+2]!=0 (out of range).
- On error: err=1 with ready, rdata=0, no memory write.
REQ-019 Valid write: write the bytes whose be bit is set, at word index addr[ADDR_WIDTH+1:2], on the DONE edge.
- rdata=0 during a write completion.
REQ-020 Valid read: rdata = full stored word at the latched index, ignoring be.
REQ-021 Outside DONE: ready=0, err=0, rdata=0.
REQ-022 A write with be=4'b0000 completes normally with err=0 and leaves memory unchanged.
REQ-023 A read in DONE returns the contents as they stood before that DONE edge; no read-during-write forwarding is needed, since only one access is in flight.

Reset
REQ-024 reset=0 forces, asynchronously: state IDLE, counter 0, latched fields 0, ready=0, err=0, rdata=0.
REQ-025 Reset asserted during BUSY or DONE aborts the access; no write is performed and no ready is issued.
REQ-026 Memory contents are not cleared by reset; they persist across reset.
REQ-027 The first access may be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 A shared include file holds the state encodings, the data width (32) and the wait-counter width (4); the top level and the bench both use it.
REQ-029 Storage is a single sub-module, mips_dmem_array: synchronous byte-enable write and combinational read, parameterised by ADDR_WIDTH.
REQ-030 The FSM, counter, address checks and output registers reside in mips_dmem_responder.

Verification
REQ-031 WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read 0x10 -> ready 3 cycles after each accept, read rdata=0xDEADBEEF, err=0.
REQ-032 Partial write be=4'b0101, wdata=0x11223344 to a word holding 0xDEADBEEF -> subsequent read returns 0xDE22BE44.
REQ-033 Read addr=0x13 (misaligned) and read addr=0x400 (out of range with ADDR_WIDTH=8) -> ready with err=1, rdata=0; memory unchanged.
REQ-034 WAIT_CYCLES=0: back-to-back req held high -> ready every 2nd cycle; req during DONE is not accepted.
REQ-035 Reset pulsed low one cycle into BUSY of a write of 0xCAFEF00D to 0x20 -> no ready; later read of 0x20 returns the prior value.
REQ-036 Change addr, we and wdata during BUSY -> completion reflects only the values latched at accept.
